// File: rtl/div_8bit_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W = $clog2(DIV_WIDTH + 1);
  localparam logic [DIV_WIDTH-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/div_8bit_seq_rbs_stage.sv
// Combinational ripple-borrow subtractor: diff = a - b, one full-subtractor per bit.
module rbs_stage #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign borrow_out = borrow[N];

endmodule

// File: rtl/div_8bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// with registered quotient/remainder/divide-by-zero and a one-cycle done pulse.
module div_8bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] DVD,
  input  logic [WIDTH-1:0] DVS,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             no_borrow;
  logic             accept;

  rbs_stage #(.N(WIDTH + 1)) u_rbs (
    .a          ({rem_q, dvd_q[WIDTH-1]}),
    .b          ({1'b0, dvs_q}),
    .diff       (trial),
    .borrow_out (borrow)
  );

  // A non-borrowing trial always has a clear top bit; folding it in keeps the full stage in use.
  assign no_borrow = ~borrow & ~trial[WIDTH];

  // The cycle where done is high already counts as idle for a new request.
  assign accept = start & ((state_q == IDLE) | ((state_q == DONE) & done_q));

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    if (accept) begin
      dvd_d   = DVD;
      dvs_d   = DVS;
      rem_d   = '0;
      quo_d   = '0;
      count_d = '0;
      busy_d  = 1'b1;
      state_d = (DVS == '0) ? DONE : CALC;
    end else begin
      case (state_q)
        CALC: begin
          rem_d   = no_borrow ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
          quo_d   = {quo_q[WIDTH-2:0], no_borrow};
          dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
          count_d = count_q + 1'b1;
          if (count_q == LAST_ITER) begin
            q_d     = quo_d;
            r_d     = rem_d;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
        DONE: begin
          // Entered straight from IDLE only for a zero divisor; publish that result here.
          if (!done_q) begin
            q_d    = {WIDTH{1'b1}};
            r_d    = dvd_q;
            dz_d   = 1'b1;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        IDLE: begin
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;

endmodule

// File: doc/div_8bit_seq.md
Name: div_8bit_seq

Overview:
- Sequential 8-bit unsigned restoring divider; the inverse arithmetic companion to the registered ripple-carry adder datapath.
- Captures dividend and divisor into input registers on a start request.
- Produces one quotient bit per clock, MSB first, using a ripple-borrow subtract stage. Reports quotient, remainder and divide-by-zero with a one-cycle done pulse.
- Sits beside the adder in the arithmetic test block, driven by the same clock.

Parameters:
- WIDTH, 8, operand/quotient/remainder width. Only 8 is verified; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- DVD  input  WIDTH  dividend, unsigned
- DVS  input  WIDTH  divisor, unsigned
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; Q/R/DZ are valid from this cycle on
- Q  output  WIDTH  quotient
- R  output  WIDTH  remainder
- DZ  output  1  divide-by-zero flag for the last result

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, Q=0, R=0, DZ=0.
  - All internal registers (operands, partial remainder, counter) cleared.
  - Reset mid-operation aborts the division; no done pulse follows.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE + start=1 at edge E0:
  - Latch DVD and DVS; clear partial remainder; count=0; busy=1.
  - If DVS==0, go to DONE. Otherwise go to CALC.
- IDLE + start=0: hold; Q/R/DZ keep the previous result.
- CALC, one iteration per edge:
  - trial = {rem[WIDTH-1:0], dvd_msb} - {1'b0, divisor}, computed WIDTH+1 bits wide by the sub-module.
  - No borrow: rem=trial[WIDTH-1:0], qbit=1. Borrow: rem={rem[WIDTH-2:0], dvd_msb}, qbit=0.
  - Shift the dividend register left by 1 and shift qbit into the quotient register LSB.
  - count increments. On the WIDTH-th iteration (edge E0+WIDTH):
    - load Q and R from the working registers; DZ=0;
    - done=1 and busy=0 for the following cycle;
    - state goes to DONE.
- DONE → IDLE on the next edge; done returns to 0.
- Latency: done is high in the cycle after edge E0+8 for normal operands and after edge E0+1 for divide-by-zero. A new start is accepted at the earliest on the edge where done is high.
- Divide-by-zero: Q=all ones (8'hFF), R=DVD, DZ=1, same done/busy sequencing.
- start while busy (CALC/DONE): ignored. DVD/DVS changes while busy: no effect, because the operands were latched.
- DVS > DVD: Q=0, R=DVD.
- Edge cases: DVD=0 gives Q=0, R=0. DVS=1 gives Q=DVD, R=0. No overflow is possible for unsigned operands.
- Invariant, checked after every done with DZ=0: Q*DVS + R == DVD and R < DVS.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, CALC, DONE};
  - constant CNT_W = $clog2(WIDTH+1);
  - constant DZ_QUOT = all-ones quotient value.
- One natural sub-module, rbs_stage: combinational WIDTH+1-bit ripple-borrow subtractor. Outputs difference and borrow-out; built as a chain of full-subtractor bits in the same ripple style as the adder chain.
- FSM, counter and shift registers stay in div_8bit_seq.

Test Plan:
- Nominal: DVD=100, DVS=7, start pulsed at edge E0 → busy=1 for 8 cycles; done=1 in the cycle after E0+8; Q=14, R=2, DZ=0.
- Extremes: 255/1 → Q=255, R=0. 5/9 → Q=0, R=5. 0/3 → Q=0, R=0. 255/255 → Q=1, R=0.
- Divide-by-zero: DVD=42, DVS=0 → done in the cycle after E0+1; Q=8'hFF, R=42, DZ=1. The next 100/7 clears DZ to 0.
- Ignored start: start held high throughout a 200/13 operation, with DVD/DVS changed mid-operation → exactly one done; Q=15, R=5. The second start is accepted on the done cycle and yields the new result 8 cycles later.
- Reset mid-operation: rst_n low for half a cycle at iteration 4 of 100/7 → all outputs 0 immediately; no done pulse; a subsequent 100/7 gives Q=14, R=2.
- Random regression: 10k random operand pairs including DVS=0 → invariant Q*DVS+R==DVD and R<DVS, or the DZ rule; done count equals accepted start count.
